// File: rtl/mux_operand_loader_pkg.sv
// Shared constants for the mux operand loader: FSM encoding, select width and slot count.
package mux_loader_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int SEL_W     = 2;
    localparam int NUM_SLOTS = 4;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_SCAN = SCAN,
        S_DONE = DONE
    } state_t;

endpackage

// File: rtl/mux_operand_loader_if.sv
// Bus between the operand loader and its environment; LOADER_WR_ERR_EN adds the wr_err strobe.
interface mux_operand_loader_if
    import mux_loader_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             wr_en;
    logic [SEL_W-1:0] wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             start;
    logic             out_ready;
    logic [WIDTH-1:0] i1;
    logic [WIDTH-1:0] i2;
    logic [WIDTH-1:0] i3;
    logic [WIDTH-1:0] i4;
    logic [SEL_W-1:0] sel;
    logic             sel_valid;
    logic             busy;
    logic             done;
`ifdef LOADER_WR_ERR_EN
    logic             wr_err;

    modport master (output wr_en, wr_addr, wr_data, start, out_ready,
                    input  i1, i2, i3, i4, sel, sel_valid, busy, done, wr_err);
    modport slave  (input  wr_en, wr_addr, wr_data, start, out_ready,
                    output i1, i2, i3, i4, sel, sel_valid, busy, done, wr_err);
`else
    modport master (output wr_en, wr_addr, wr_data, start, out_ready,
                    input  i1, i2, i3, i4, sel, sel_valid, busy, done);
    modport slave  (input  wr_en, wr_addr, wr_data, start, out_ready,
                    output i1, i2, i3, i4, sel, sel_valid, busy, done);
`endif
endinterface

// File: rtl/mux_operand_loader_slot_regfile.sv
// Four operand registers feeding the mux data inputs; writes are gated by the caller.
module slot_regfile
    import mux_loader_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [SEL_W-1:0] addr,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [WIDTH-1:0] q4
);
    logic [WIDTH-1:0] slot_r [NUM_SLOTS];

    // Slot storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_r[i] <= {WIDTH{1'b0}};
            end
        end else if (we) begin
            slot_r[addr] <= data;
        end else begin
            slot_r <= slot_r;
        end
    end

    assign q1 = slot_r[0];
    assign q2 = slot_r[1];
    assign q3 = slot_r[2];
    assign q4 = slot_r[3];
endmodule

// File: rtl/mux_operand_loader.sv
// Sequences stored operands through the 4:1 mux, one slot per accepted handshake.
// Optional macro LOADER_WR_ERR_EN flags writes dropped while a scan is in progress.
module mux_operand_loader
    import mux_loader_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SCAN_LAST = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    mux_operand_loader_if.slave  bus
);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(SCAN_LAST);

    state_t           state_r;
    logic [SEL_W-1:0] sel_r;
    logic             sel_valid_r;
    logic             busy_r;
    logic             done_r;
    logic             wr_gate_s;

    // Registers only accept writes in IDLE so a scan sees frozen operands.
    always_comb begin
        wr_gate_s = 1'b0;
        if (state_r == S_IDLE) begin
            wr_gate_s = bus.wr_en;
        end else begin
            wr_gate_s = 1'b0;
        end
    end

    slot_regfile #(.WIDTH(WIDTH)) u_slots (
        .clk  (clk),
        .rst  (rst),
        .we   (wr_gate_s),
        .addr (bus.wr_addr),
        .data (bus.wr_data),
        .q1   (bus.i1),
        .q2   (bus.i2),
        .q3   (bus.i3),
        .q4   (bus.i4)
    );

    // Scan FSM with registered select and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            sel_r       <= {SEL_W{1'b0}};
            sel_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    sel_r  <= {SEL_W{1'b0}};
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state_r     <= S_SCAN;
                        sel_valid_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end else begin
                        sel_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (bus.out_ready) begin
                        if (sel_r == LAST_SEL) begin
                            state_r     <= S_DONE;
                            sel_valid_r <= 1'b0;
                            done_r      <= 1'b1;
                        end else begin
                            sel_r <= sel_r + {{(SEL_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        sel_r <= sel_r;
                    end
                end
                S_DONE: begin
                    state_r     <= S_IDLE;
                    sel_r       <= {SEL_W{1'b0}};
                    sel_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
                default: begin
                    state_r     <= S_IDLE;
                    sel_r       <= {SEL_W{1'b0}};
                    sel_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

`ifdef LOADER_WR_ERR_EN
    logic wr_err_r;

    // One-cycle flag for a write that arrived outside IDLE and was discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err_r <= 1'b0;
        end else begin
            wr_err_r <= bus.wr_en && (state_r != S_IDLE);
        end
    end

    assign bus.wr_err = wr_err_r;
`endif

    assign bus.sel       = sel_r;
    assign bus.sel_valid = sel_valid_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
endmodule

// File: tb/tb_mux_operand_loader.sv
// Directed and randomized bench for mux_operand_loader against a slot-array reference model.
module tb_mux_operand_loader;
    import mux_loader_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;
    logic [W-1:0] model_a [4];
    logic [W-1:0] model_b [4];

    always #5 clk = ~clk;

    mux_operand_loader_if #(.WIDTH(W)) bus_a ();
    mux_operand_loader_if #(.WIDTH(W)) bus_b ();

    mux_operand_loader #(.WIDTH(W), .SCAN_LAST(3)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    mux_operand_loader #(.WIDTH(W), .SCAN_LAST(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pick(input logic [1:0] s, input logic [W-1:0] a, b, c, d);
        case (s)
            2'd0:    return a;
            2'd1:    return b;
            2'd2:    return c;
            default: return d;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [1:0] a, input logic [W-1:0] d);
        bus_a.wr_en = 1'b1; bus_a.wr_addr = a; bus_a.wr_data = d;
        tick();
        bus_a.wr_en = 1'b0;
        model_a[a] = d;
    endtask

    task automatic check_regs_a(input string tag);
        chk({tag, "_i1"}, 32'(bus_a.i1), 32'(model_a[0]));
        chk({tag, "_i2"}, 32'(bus_a.i2), 32'(model_a[1]));
        chk({tag, "_i3"}, 32'(bus_a.i3), 32'(model_a[2]));
        chk({tag, "_i4"}, 32'(bus_a.i4), 32'(model_a[3]));
    endtask

    // Full scan on dut_a: expected presentation order is model_a[0..3], one per handshake.
    task automatic run_scan_a(input bit rnd, input int stall_idx, input int stall_n,
                              input bit wr_start, input logic [1:0] ws_a, input logic [W-1:0] ws_d,
                              input int wr_idx, input logic [1:0] wa, input logic [W-1:0] wd);
        int idx = 0;
        int stalled = 0;
        int cycles = 0;
        bit ready;
        bit wrote = 1'b0;
        bit exp_err = 1'b0;
        bus_a.start = 1'b1;
        if (wr_start) begin
            bus_a.wr_en = 1'b1; bus_a.wr_addr = ws_a; bus_a.wr_data = ws_d;
            model_a[ws_a] = ws_d;
        end
        tick();
        bus_a.start = 1'b0;
        bus_a.wr_en = 1'b0;
        while (idx <= 3 && cycles < 200) begin
            chk("scan_sel", 32'(bus_a.sel), 32'(idx));
            chk("scan_valid", 32'(bus_a.sel_valid), 32'd1);
            chk("scan_busy", 32'(bus_a.busy), 32'd1);
            chk("scan_done", 32'(bus_a.done), 32'd0);
            chk("scan_mux", 32'(pick(bus_a.sel, bus_a.i1, bus_a.i2, bus_a.i3, bus_a.i4)), 32'(model_a[idx]));
`ifdef LOADER_WR_ERR_EN
            chk("scan_wr_err", 32'(bus_a.wr_err), 32'(exp_err));
`endif
            if (idx == stall_idx && stalled < stall_n) begin
                ready = 1'b0;
                stalled++;
            end else begin
                ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            bus_a.out_ready = ready;
            bus_a.start     = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            if (idx == wr_idx && !wrote) begin
                bus_a.wr_en = 1'b1; bus_a.wr_addr = wa; bus_a.wr_data = wd;
                wrote = 1'b1;
            end else begin
                bus_a.wr_en   = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
                bus_a.wr_addr = 2'($urandom_range(0, 3));
                bus_a.wr_data = 8'($urandom);
            end
            exp_err = bus_a.wr_en;
            tick();
            cycles++;
            if (ready) idx++;
        end
        chk("scan_bound", 32'(cycles < 200), 32'd1);
        chk("done_pulse", 32'(bus_a.done), 32'd1);
        chk("done_busy", 32'(bus_a.busy), 32'd1);
        chk("done_valid", 32'(bus_a.sel_valid), 32'd0);
        chk("done_sel", 32'(bus_a.sel), 32'd3);
`ifdef LOADER_WR_ERR_EN
        chk("done_wr_err", 32'(bus_a.wr_err), 32'(exp_err));
`endif
        bus_a.out_ready = 1'b0;
        bus_a.start     = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        bus_a.wr_en     = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        bus_a.wr_data   = 8'($urandom);
        exp_err = bus_a.wr_en;
        tick();
        bus_a.start = 1'b0;
        bus_a.wr_en = 1'b0;
        chk("idle_done", 32'(bus_a.done), 32'd0);
        chk("idle_busy", 32'(bus_a.busy), 32'd0);
        chk("idle_sel", 32'(bus_a.sel), 32'd0);
        chk("idle_valid", 32'(bus_a.sel_valid), 32'd0);
`ifdef LOADER_WR_ERR_EN
        chk("idle_wr_err", 32'(bus_a.wr_err), 32'(exp_err));
`endif
        check_regs_a("post_scan");
    endtask

    initial begin
        bus_a.wr_en = 1'b0; bus_a.wr_addr = 2'd0; bus_a.wr_data = 8'h00;
        bus_a.start = 1'b0; bus_a.out_ready = 1'b0;
        bus_b.wr_en = 1'b0; bus_b.wr_addr = 2'd0; bus_b.wr_data = 8'h00;
        bus_b.start = 1'b0; bus_b.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            model_a[i] = 8'h00;
            model_b[i] = 8'h00;
        end

        // 1. reset then idle
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_sel", 32'(bus_a.sel), 32'd0);
        chk("rst_valid", 32'(bus_a.sel_valid), 32'd0);
        chk("rst_busy", 32'(bus_a.busy), 32'd0);
        chk("rst_done", 32'(bus_a.done), 32'd0);
        check_regs_a("rst");
        chk("rst_b_sel", 32'(bus_b.sel), 32'd0);
        chk("rst_b_busy", 32'(bus_b.busy), 32'd0);
`ifdef LOADER_WR_ERR_EN
        chk("rst_wr_err", 32'(bus_a.wr_err), 32'd0);
`endif

        // 2. load and full scan
        write_a(2'd0, 8'h11);
        write_a(2'd1, 8'h22);
        write_a(2'd2, 8'h33);
        write_a(2'd3, 8'h44);
        check_regs_a("load");
        run_scan_a(1'b0, -1, 0, 1'b0, 2'd0, 8'h00, -1, 2'd0, 8'h00);

        // 3. back-pressure at sel=1
        run_scan_a(1'b0, 1, 3, 1'b0, 2'd0, 8'h00, -1, 2'd0, 8'h00);

        // 4. write during scan is dropped
        run_scan_a(1'b0, -1, 0, 1'b0, 2'd0, 8'h00, 0, 2'd2, 8'hAA);
        chk("drop_slot2", 32'(bus_a.i3), 32'h33);

        // 5. simultaneous write and start
        run_scan_a(1'b0, -1, 0, 1'b1, 2'd0, 8'h5C, -1, 2'd0, 8'h00);

        // randomized scans with random back-pressure and stray writes
        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < 3; k++) begin
                write_a(2'($urandom_range(0, 3)), 8'($urandom));
            end
            run_scan_a(1'b1, -1, 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       8'($urandom), -1, 2'd0, 8'h00);
        end

        // 6b. SCAN_LAST=1 covers slots 0 and 1 only
        for (int i = 0; i < 4; i++) begin
            bus_b.wr_en = 1'b1; bus_b.wr_addr = 2'(i); bus_b.wr_data = 8'(8'h0B + 8'(i * 16));
            model_b[i] = 8'(8'h0B + 8'(i * 16));
            tick();
        end
        bus_b.wr_en = 1'b0;
        bus_b.start = 1'b1;
        bus_b.out_ready = 1'b1;
        tick();
        bus_b.start = 1'b0;
        for (int s = 0; s < 2; s++) begin
            chk("b_sel", 32'(bus_b.sel), 32'(s));
            chk("b_valid", 32'(bus_b.sel_valid), 32'd1);
            chk("b_mux", 32'(pick(bus_b.sel, bus_b.i1, bus_b.i2, bus_b.i3, bus_b.i4)), 32'(model_b[s]));
            tick();
        end
        chk("b_done", 32'(bus_b.done), 32'd1);
        chk("b_done_sel", 32'(bus_b.sel), 32'd1);
        chk("b_done_valid", 32'(bus_b.sel_valid), 32'd0);
        bus_b.out_ready = 1'b0;
        tick();
        chk("b_idle_done", 32'(bus_b.done), 32'd0);
        chk("b_idle_busy", 32'(bus_b.busy), 32'd0);

        // 6a. reset mid-scan at sel=2
        bus_a.start = 1'b1;
        bus_a.out_ready = 1'b1;
        tick();
        bus_a.start = 1'b0;
        tick();
        tick();
        chk("mid_sel2", 32'(bus_a.sel), 32'd2);
        rst = 1'b1;
        bus_a.out_ready = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) model_a[i] = 8'h00;
        chk("mid_rst_sel", 32'(bus_a.sel), 32'd0);
        chk("mid_rst_valid", 32'(bus_a.sel_valid), 32'd0);
        chk("mid_rst_busy", 32'(bus_a.busy), 32'd0);
        chk("mid_rst_done", 32'(bus_a.done), 32'd0);
        check_regs_a("mid_rst");
        tick();
        chk("mid_rst_no_done", 32'(bus_a.done), 32'd0);
        chk("mid_rst_idle_busy", 32'(bus_a.busy), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
